// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, default datapath geometry and
// the signed saturation bounds used by the clamping adder.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;
    localparam int unsigned MAX_WIDTH     = 64;

    // Signed max (negative = 0) or signed min (negative = 1) for a width-bit
    // two's-complement value, right-aligned in MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] sat_bound(input int unsigned width,
                                                       input logic        negative);
        logic [MAX_WIDTH-1:0] bound;
        bound = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
        if (!negative) begin
            bound = bound - 1'b1;
        end
        return bound;
    endfunction

endpackage

// File: rtl/pipe_addsub_stage.sv
// One CHUNK-bit slice of the pipelined adder: resolves slice IDX with the
// carry handed over by the previous stage and registers the whole beat.
module pipe_addsub_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_s,
    input  logic             up_carry,
    input  logic             up_sat,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             sat
);

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] s_next;

    assign slice_sum = {1'b0, up_a[IDX*CHUNK +: CHUNK]}
                     + {1'b0, up_b[IDX*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, up_carry};

    always_comb begin
        s_next = up_s;
        s_next[IDX*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    // NOTE: non-blocking assignments keep every stage sampling the values its
    // neighbour held before this edge, so beats shift one stage per clock.
    // NOTE: the data registers are reset too, not just valid, because the
    // last stage drives out_s/out_cout/out_ovf directly and they must read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            s     <= '0;
            carry <= 1'b0;
            sat   <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                a     <= up_a;
                b     <= up_b;
                s     <= s_next;
                carry <= slice_sum[CHUNK];
                sat   <= up_sat;
            end
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor resolving CHUNK bits per stage with a
// bubble-collapsing valid/ready pipeline. Optional clamp: PIPE_ADDSUB_SAT_EN.
module pipe_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned STAGES = WIDTH / ((CHUNK == 0) ? 1 : CHUNK);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] s_q     [STAGES];
    logic             carry_q [STAGES];
    logic             sat_q   [STAGES];
    logic [STAGES-1:0] stage_load;

    // Subtraction becomes A + ~B + 1 right at capture, so stages only add.
    logic [WIDTH-1:0] b_cap;
    logic             carry_cap;
    logic             sat_cap;

    assign b_cap     = (in_op == OP_SUB) ? ~in_b : in_b;
    assign carry_cap = (in_op == OP_SUB) ? 1'b1 : in_cin;
`ifdef PIPE_ADDSUB_SAT_EN
    assign sat_cap   = in_sat;
`else
    assign sat_cap   = 1'b0;
`endif

    // A stage may load when it, or any stage below it, has a free slot.
    always_comb begin
        logic room;
        stage_load = '0;
        room = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room = room || !valid_q[k];
            stage_load[k] = room;
        end
    end

    assign in_ready = stage_load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_addsub_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (stage_load[k]),
                .up_valid (in_valid),
                .up_a     (in_a),
                .up_b     (b_cap),
                .up_s     ({WIDTH{1'b0}}),
                .up_carry (carry_cap),
                .up_sat   (sat_cap),
                .valid    (valid_q[k]),
                .a        (a_q[k]),
                .b        (b_q[k]),
                .s        (s_q[k]),
                .carry    (carry_q[k]),
                .sat      (sat_q[k])
            );
        end else begin : g_body
            pipe_addsub_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (stage_load[k]),
                .up_valid (valid_q[k-1]),
                .up_a     (a_q[k-1]),
                .up_b     (b_q[k-1]),
                .up_s     (s_q[k-1]),
                .up_carry (carry_q[k-1]),
                .up_sat   (sat_q[k-1]),
                .valid    (valid_q[k]),
                .a        (a_q[k]),
                .b        (b_q[k]),
                .s        (s_q[k]),
                .carry    (carry_q[k]),
                .sat      (sat_q[k])
            );
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    logic msb_carry_in;
    assign msb_carry_in = s_q[STAGES-1][WIDTH-1] ^ a_q[STAGES-1][WIDTH-1]
                        ^ b_q[STAGES-1][WIDTH-1];

    assign out_valid = valid_q[STAGES-1];
    assign out_cout  = carry_q[STAGES-1];
    assign out_ovf   = out_cout ^ msb_carry_in;

`ifdef PIPE_ADDSUB_SAT_EN
    // On overflow both operands share a sign, which is the sign of the true result.
    logic [WIDTH-1:0] clamp_value;
    assign clamp_value = WIDTH'(sat_bound(WIDTH, a_q[STAGES-1][WIDTH-1]));
    assign out_s = (sat_q[STAGES-1] && out_ovf) ? clamp_value : s_q[STAGES-1];
`else
    assign out_s = s_q[STAGES-1];
`endif

    logic unused_last_stage;
    assign unused_last_stage = ^{a_q[STAGES-1], b_q[STAGES-1], sat_q[STAGES-1]};

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH 16, CHUNK 4) against a plain
// integer-arithmetic reference model; define PIPE_ADDSUB_SAT_EN for clamp tests.
module tb_pipe_addsub;
    import alu_pkg::*;

    localparam int W      = 16;
    localparam int C      = 4;
    localparam int STAGES = W / C;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op;
        logic         sat;
    } beat_t;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_op;
`ifdef PIPE_ADDSUB_SAT_EN
    logic         in_sat;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_cout;
    logic         out_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
`ifdef PIPE_ADDSUB_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true signed/unsigned results from integer arithmetic.
    function automatic res_t model(input beat_t bt);
        res_t   r;
        longint ua, ub, full;
        int     sa, sb, true_val;
        ua = longint'(bt.a);
        ub = longint'(bt.b);
        sa = int'($signed(bt.a));
        sb = int'($signed(bt.b));
        if (bt.op == OP_SUB) begin
            true_val = sa - sb;
            full     = ua - ub;
            r.cout   = (ua >= ub);
        end else begin
            true_val = sa + sb + int'(bt.cin);
            full     = ua + ub + longint'(bt.cin);
            r.cout   = (full > 65535);
        end
        r.s   = full[W-1:0];
        r.ovf = (true_val > 32767) || (true_val < -32768);
        if (bt.sat && r.ovf) begin
            r.s = (true_val > 0) ? 16'h7FFF : 16'h8000;
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        bt.a   = W'($urandom);
        bt.b   = W'($urandom);
        bt.cin = 1'($urandom);
        bt.op  = 1'($urandom);
`ifdef PIPE_ADDSUB_SAT_EN
        bt.sat = 1'($urandom);
`else
        bt.sat = 1'b0;
`endif
        return bt;
    endfunction

    task automatic set_beat(input beat_t bt);
        in_a   = bt.a;
        in_b   = bt.b;
        in_cin = bt.cin;
        in_op  = bt.op;
`ifdef PIPE_ADDSUB_SAT_EN
        in_sat = bt.sat;
`endif
    endtask

    // Sends one beat into an empty pipe; reports result and edges to out_valid.
    task automatic single_beat(input beat_t bt, output res_t got, output int lat,
                               output logic seen);
        @(negedge clk);
        set_beat(bt);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        set_beat(rand_beat());
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        seen     = out_valid;
        got.s    = out_s;
        got.cout = out_cout;
        got.ovf  = out_ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_beat(rand_beat());
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
        end
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_s !== 16'h0) $display("FAIL reset_out_s: got %h expected 0000", out_s); else pass_cnt++;
        total_cnt++; if (out_cout !== 1'b0) $display("FAIL reset_out_cout: got %b expected 0", out_cout); else pass_cnt++;
        total_cnt++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); else pass_cnt++;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_add_carry();
        res_t got, exp;
        int   lat;
        logic seen;
        beat_t bt;
        bt = '{16'hFFFF, 16'h0001, 1'b0, OP_ADD, 1'b0};
        single_beat(bt, got, lat, seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL add_timeout: out_valid got %b expected 1", seen); else pass_cnt++;
        total_cnt++; if (lat != STAGES) $display("FAIL add_latency: got %0d expected %0d", lat, STAGES); else pass_cnt++;
        total_cnt++; if (got.s !== 16'h0000) $display("FAIL add_s: got %h expected 0000", got.s); else pass_cnt++;
        total_cnt++; if (got.cout !== 1'b1) $display("FAIL add_cout: got %b expected 1", got.cout); else pass_cnt++;
        total_cnt++; if (got.ovf !== 1'b0) $display("FAIL add_ovf: got %b expected 0", got.ovf); else pass_cnt++;
        bt = '{16'h1234, 16'h0FCB, 1'b1, OP_ADD, 1'b0};
        exp = model(bt);
        single_beat(bt, got, lat, seen);
        total_cnt++;
        if ({seen, got.s, got.cout, got.ovf} !== {1'b1, exp.s, exp.cout, exp.ovf})
            $display("FAIL add_cin: got v%b %h c%b o%b expected v1 %h c%b o%b",
                     seen, got.s, got.cout, got.ovf, exp.s, exp.cout, exp.ovf);
        else pass_cnt++;
    endtask

    task automatic test_sub();
        res_t got;
        int   lat;
        logic seen;
        single_beat('{16'h8000, 16'h0001, 1'b0, OP_SUB, 1'b0}, got, lat, seen);
        total_cnt++; if ({seen, got.s} !== {1'b1, 16'h7FFF}) $display("FAIL sub1_s: got v%b %h expected v1 7fff", seen, got.s); else pass_cnt++;
        total_cnt++; if (got.cout !== 1'b1) $display("FAIL sub1_cout: got %b expected 1", got.cout); else pass_cnt++;
        total_cnt++; if (got.ovf !== 1'b1) $display("FAIL sub1_ovf: got %b expected 1", got.ovf); else pass_cnt++;
        // cin is set here to show it is ignored for subtraction
        single_beat('{16'h0003, 16'h0005, 1'b1, OP_SUB, 1'b0}, got, lat, seen);
        total_cnt++; if ({seen, got.s} !== {1'b1, 16'hFFFE}) $display("FAIL sub2_s: got v%b %h expected v1 fffe", seen, got.s); else pass_cnt++;
        total_cnt++; if (got.cout !== 1'b0) $display("FAIL sub2_cout: got %b expected 0", got.cout); else pass_cnt++;
        total_cnt++; if (got.ovf !== 1'b0) $display("FAIL sub2_ovf: got %b expected 0", got.ovf); else pass_cnt++;
    endtask

`ifdef PIPE_ADDSUB_SAT_EN
    task automatic test_sat();
        res_t got;
        int   lat;
        logic seen;
        single_beat('{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 1'b1}, got, lat, seen);
        total_cnt++; if ({seen, got.s, got.ovf} !== {1'b1, 16'h7FFF, 1'b1}) $display("FAIL sat_pos: got v%b %h o%b expected v1 7fff o1", seen, got.s, got.ovf); else pass_cnt++;
        single_beat('{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 1'b0}, got, lat, seen);
        total_cnt++; if ({seen, got.s, got.ovf} !== {1'b1, 16'h8000, 1'b1}) $display("FAIL sat_off: got v%b %h o%b expected v1 8000 o1", seen, got.s, got.ovf); else pass_cnt++;
        single_beat('{16'h8000, 16'h0001, 1'b0, OP_SUB, 1'b1}, got, lat, seen);
        total_cnt++; if ({seen, got.s, got.cout} !== {1'b1, 16'h8000, 1'b1}) $display("FAIL sat_neg: got v%b %h c%b expected v1 8000 c1", seen, got.s, got.cout); else pass_cnt++;
    endtask
`endif

    // Random valid gaps and random backpressure, checked in order against the model.
    task automatic test_back_to_back();
        localparam int N = 40;
        beat_t beats[N];
        res_t  exp_q[$];
        res_t  exp;
        int    sent = 0, recv = 0, cyc = 0;
        for (int i = 0; i < N; i++) beats[i] = rand_beat();
        while (recv < N && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom % 4) != 0;
            if (sent < N && ($urandom % 4) != 0) begin
                set_beat(beats[sent]);
                in_valid = 1'b1;
            end else begin
                set_beat(rand_beat());
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(beats[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got beat %h with nothing expected", out_s);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_s, out_cout, out_ovf} !== {exp.s, exp.cout, exp.ovf})
                        $display("FAIL stream_beat%0d: got %h c%b o%b expected %h c%b o%b",
                                 recv, out_s, out_cout, out_ovf, exp.s, exp.cout, exp.ovf);
                    else pass_cnt++;
                end
                recv++;
            end
        end
        in_valid = 1'b0;
        total_cnt++; if (recv != N) $display("FAIL stream_count: got %0d expected %0d", recv, N); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        localparam int N = 10;
        beat_t beats[N];
        res_t  exp_q[$];
        res_t  exp;
        logic [W+1:0] held;
        int    sent = 0, recv = 0, cyc = 0;
        for (int i = 0; i < N; i++) beats[i] = rand_beat();
        while (recv < N && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 9);
            if (sent < N) begin
                set_beat(beats[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 4) held = {out_s, out_cout, out_ovf};
            if (cyc == 4) begin
                total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_first_out: got %b expected 1", out_valid); else pass_cnt++;
            end
            if (cyc == 6) begin
                total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); else pass_cnt++;
            end
            if (cyc == 9) begin
                total_cnt++; if (sent != 4) $display("FAIL bp_held: got %0d accepted expected 4", sent); else pass_cnt++;
                total_cnt++; if ({out_s, out_cout, out_ovf} !== held) $display("FAIL bp_stable: got %h expected %h", {out_s, out_cout, out_ovf}, held); else pass_cnt++;
            end
            if (cyc == 10) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_full_drain: in_ready got %b expected 1", in_ready); else pass_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(beats[sent]));
                sent++;
            end
            if (out_valid && out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_extra: got beat %h with nothing expected", out_s);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_s, out_cout, out_ovf} !== {exp.s, exp.cout, exp.ovf})
                        $display("FAIL bp_beat%0d: got %h c%b o%b expected %h c%b o%b",
                                 recv, out_s, out_cout, out_ovf, exp.s, exp.cout, exp.ovf);
                    else pass_cnt++;
                end
                recv++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total_cnt++; if (recv != N) $display("FAIL bp_count: got %0d expected %0d", recv, N); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        int   stale = 0;
        res_t got, exp;
        int   lat;
        logic seen;
        beat_t bt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_beat(rand_beat());
            in_valid  = 1'b1;
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_s !== 16'h0) $display("FAIL midrst_out_s: got %h expected 0000", out_s); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total_cnt++; if (stale != 0) $display("FAIL midrst_stale: got %0d beats expected 0", stale); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        bt = rand_beat();
        exp = model(bt);
        single_beat(bt, got, lat, seen);
        total_cnt++;
        if ({seen, got.s, got.cout, got.ovf} !== {1'b1, exp.s, exp.cout, exp.ovf})
            $display("FAIL midrst_after: got v%b %h c%b o%b expected v1 %h c%b o%b",
                     seen, got.s, got.cout, got.ovf, exp.s, exp.cout, exp.ovf);
        else pass_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_beat('{16'h0, 16'h0, 1'b0, OP_ADD, 1'b0});
        test_reset();
        test_add_carry();
        test_sub();
`ifdef PIPE_ADDSUB_SAT_EN
        test_sat();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
